// File: rtl/fxp_mac_array.sv
// rtl/fxp_mac_array.sv - multi-lane fixed-point multiply/accumulate pipeline with rounding and saturation
// Stage 1 multiplies, stage 2 accumulates, stage 3 scales and clamps, stages 4..DELAY delay the result.
module fxp_mac_array #(
    parameter int LANES     = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int A_FRAC    = 15,
    parameter int B_FRAC    = 15,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_FRAC  = 15,
    parameter int ACC_WIDTH = 40,
    parameter int DELAY     = 3,
    parameter int ROUND     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       stall,
    input  logic                       mode,
    input  logic                       acc_clear,
    input  logic [LANES*A_WIDTH-1:0]   a_in,
    input  logic [LANES*B_WIDTH-1:0]   b_in,
    output logic [LANES*OUT_WIDTH-1:0] out,
    output logic [LANES-1:0]           sat,
    output logic                       done
);
    localparam int PW      = A_WIDTH + B_WIDTH;
    localparam int SH      = A_FRAC + B_FRAC - OUT_FRAC;
    localparam int RSH     = (SH > 0) ? SH : 0;
    localparam int LSH     = (SH < 0) ? -SH : 0;
    // Two guard bits keep the rounding add and the left shift from wrapping before the clamp.
    localparam int EW      = ACC_WIDTH + LSH + 2;
    localparam int RND_POS = (RSH > 0) ? RSH - 1 : 0;

    localparam logic signed [EW-1:0] RND =
        (ROUND != 0 && RSH > 0) ? (EW'(1) <<< RND_POS) : '0;
    localparam logic signed [EW-1:0] OUT_MAX = (EW'(1) <<< (OUT_WIDTH - 1)) - EW'(1);
    localparam logic signed [EW-1:0] OUT_MIN = -(EW'(1) <<< (OUT_WIDTH - 1));
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [DELAY:1] vld_q;

    logic signed [PW-1:0] prod_d [LANES];
    logic signed [PW-1:0] prod_q [LANES];
    logic                 mode_q;
    logic                 clear_q;

    logic signed [ACC_WIDTH-1:0] acc_d   [LANES];
    logic signed [ACC_WIDTH-1:0] acc_q   [LANES];
    logic signed [ACC_WIDTH:0]   acc_sum [LANES];
    logic [LANES-1:0]            acc_sat_d;
    logic [LANES-1:0]            acc_sat_q;

    logic signed [EW-1:0]       scaled [LANES];
    logic [LANES*OUT_WIDTH-1:0] out3_d;
    logic [LANES-1:0]           sat3_d;

    logic [LANES*OUT_WIDTH-1:0] out_q [3:DELAY];
    logic [LANES-1:0]           sat_q [3:DELAY];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = PW'($signed(a_in[i*A_WIDTH +: A_WIDTH]))
                      * PW'($signed(b_in[i*B_WIDTH +: B_WIDTH]));
        end
    end

    always_comb begin
        acc_sat_d = '0;
        for (int i = 0; i < LANES; i++) begin
            acc_sum[i] = (ACC_WIDTH+1)'(acc_q[i]) + (ACC_WIDTH+1)'(prod_q[i]);
            if (!mode_q || clear_q) begin
                acc_d[i] = ACC_WIDTH'(prod_q[i]);
            end else if (acc_sum[i][ACC_WIDTH] != acc_sum[i][ACC_WIDTH-1]) begin
                acc_d[i]     = acc_sum[i][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                acc_sat_d[i] = 1'b1;
            end else begin
                acc_d[i] = acc_sum[i][ACC_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        out3_d = '0;
        sat3_d = '0;
        for (int i = 0; i < LANES; i++) begin
            scaled[i] = ((EW'(acc_q[i]) + RND) >>> RSH) <<< LSH;
            if (scaled[i] > OUT_MAX) begin
                out3_d[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
                sat3_d[i]                        = 1'b1;
            end else if (scaled[i] < OUT_MIN) begin
                out3_d[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
                sat3_d[i]                        = 1'b1;
            end else begin
                out3_d[i*OUT_WIDTH +: OUT_WIDTH] = scaled[i][OUT_WIDTH-1:0];
            end
            sat3_d[i] = sat3_d[i] | acc_sat_q[i];
        end
    end

    // Each stage loads only when its valid bit says a beat is arriving, so idle cycles never disturb state.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q     <= '0;
            mode_q    <= 1'b0;
            clear_q   <= 1'b0;
            acc_sat_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
            end
            for (int k = 3; k <= DELAY; k++) begin
                out_q[k] <= '0;
                sat_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_q <= {vld_q[DELAY-1:1], en};
            if (en) begin
                prod_q  <= prod_d;
                mode_q  <= mode;
                clear_q <= acc_clear;
            end
            if (vld_q[1]) begin
                acc_q     <= acc_d;
                acc_sat_q <= acc_sat_d;
            end
            if (vld_q[2]) begin
                out_q[3] <= out3_d;
                sat_q[3] <= sat3_d;
            end
            for (int k = 4; k <= DELAY; k++) begin
                out_q[k] <= out_q[k-1];
                sat_q[k] <= sat_q[k-1];
            end
        end
    end

    assign out  = out_q[DELAY];
    assign sat  = sat_q[DELAY];
    assign done = vld_q[DELAY] & ~reset;

endmodule

// File: tb/tb_fxp_mac_array.sv
// tb/tb_fxp_mac_array.sv - scoreboard bench for fxp_mac_array, ROUND=1 and ROUND=0 instances side by side
module tb_fxp_mac_array;
    localparam int DELAY = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        mode = 1'b0;
    logic        acc_clear = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic [63:0] out_r1, out_r0;
    logic [3:0]  sat_r1, sat_r0;
    logic        done_r1, done_r0;

    fxp_mac_array #(.ROUND(1)) dut_r1 (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .mode(mode), .acc_clear(acc_clear),
        .a_in(a_in), .b_in(b_in), .out(out_r1), .sat(sat_r1), .done(done_r1)
    );

    fxp_mac_array #(.ROUND(0)) dut_r0 (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .mode(mode), .acc_clear(acc_clear),
        .a_in(a_in), .b_in(b_in), .out(out_r0), .sat(sat_r0), .done(done_r0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] o1;
        logic [63:0] o0;
        logic [3:0]  s1;
        logic [3:0]  s0;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t hold;
    bit   hold_valid = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   nsc = 0;
    bit   edge_stall = 1'b0;
    bit   edge_reset = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // nsc counts the edges at which the pipeline advanced; a beat is due DELAY such edges after it is driven.
    always @(posedge clk) begin
        edge_stall <= stall;
        edge_reset <= reset;
        if (!stall && !reset) nsc <= nsc + 1;
    end

    always @(negedge clk) begin
        logic exp_d;
        if (reset) begin
            check("done_in_reset", 64'(done_r1), 64'd0);
            hold_valid = 1'b0;
        end else if (edge_stall && !edge_reset) begin
            check("done_hold", 64'(done_r1), 64'(hold_valid));
            if (hold_valid) begin
                check("out_hold_r1", out_r1, hold.o1);
                check("out_hold_r0", out_r0, hold.o0);
            end
        end else begin
            exp_d = (sb.size() > 0) && (sb[0].due == nsc);
            check("done_r1", 64'(done_r1), 64'(exp_d));
            check("done_r0", 64'(done_r0), 64'(exp_d));
            if (exp_d) begin
                hold = sb.pop_front();
                check("out_r1", out_r1, hold.o1);
                check("sat_r1", 64'(sat_r1), 64'(hold.s1));
                check("out_r0", out_r0, hold.o0);
                check("sat_r0", 64'(sat_r0), 64'(hold.s0));
                hold_valid = 1'b1;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic step(input logic e, st, m, c, input logic [63:0] a, b, o1, o0,
                        input logic [3:0] s1, s0);
        exp_t x;
        en = e; stall = st; mode = m; acc_clear = c; a_in = a; b_in = b;
        if (e && !st && !reset) begin
            x.o1 = o1; x.o0 = o0; x.s1 = s1; x.s0 = s0; x.due = nsc + DELAY;
            sb.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; stall = 1'b1; en = 1'b0;
        sb.delete();
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("out_after_reset", out_r1, 64'd0);
        check("sat_after_reset", 64'(sat_r1), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset(3);

        // single multiply and plain saturation
        step(1, 0, 0, 0, 64'h4000, 64'h4000, 64'h2000, 64'h2000, 4'b0000, 4'b0000);
        idle(4);
        step(1, 0, 0, 0, 64'h8000, 64'h8000, 64'h7FFF, 64'h7FFF, 4'b0001, 4'b0001);
        idle(4);
        // independent lanes: 0.25, +1 clamp, -0.25, -32767/32768
        step(1, 0, 0, 0, 64'h7FFF_C000_8000_4000, 64'h8000_4000_8000_4000,
             64'h8001_E000_7FFF_2000, 64'h8001_E000_7FFF_2000, 4'b0010, 4'b0010);
        idle(4);

        // four back-to-back accumulate beats
        step(1, 0, 1, 1, 64'h4000, 64'h4000, 64'h2000, 64'h2000, 4'b0000, 4'b0000);
        step(1, 0, 1, 0, 64'h4000, 64'h4000, 64'h4000, 64'h4000, 4'b0000, 4'b0000);
        step(1, 0, 1, 0, 64'h4000, 64'h4000, 64'h6000, 64'h6000, 4'b0000, 4'b0000);
        step(1, 0, 1, 0, 64'h4000, 64'h4000, 64'h7FFF, 64'h7FFF, 4'b0001, 4'b0001);
        idle(4);

        // mode=0 reloads, acc_clear ignored with mode=0 or en=0
        step(1, 0, 0, 0, 64'h4000, 64'h4000, 64'h2000, 64'h2000, 4'b0000, 4'b0000);
        step(1, 0, 1, 0, 64'h4000, 64'h4000, 64'h4000, 64'h4000, 4'b0000, 4'b0000);
        step(1, 0, 0, 1, 64'h2000, 64'h4000, 64'h1000, 64'h1000, 4'b0000, 4'b0000);
        step(1, 0, 1, 0, 64'h4000, 64'h4000, 64'h3000, 64'h3000, 4'b0000, 4'b0000);
        step(0, 0, 1, 1, 64'h4000, 64'h4000, '0, '0, '0, '0);
        step(1, 0, 1, 0, 64'h4000, 64'h4000, 64'h5000, 64'h5000, 4'b0000, 4'b0000);
        idle(4);

        // rounding half-up versus truncation
        step(1, 0, 0, 0, 64'hFFFF_0001_FFFF_0001, 64'hC000_2000_4000_4000,
             64'h0001_0000_0000_0001, 64'h0000_0000_FFFF_0000, 4'b0000, 4'b0000);
        idle(4);
        // rounding pushes lane0 over the top; lane1 accumulates past the negative limit
        step(1, 0, 1, 1, 64'h0000_0000_8000_7FFF, 64'h0000_0000_7FFF_7FFF,
             64'h0000_0000_8001_7FFE, 64'h0000_0000_8001_7FFE, 4'b0000, 4'b0000);
        step(1, 0, 1, 0, 64'h0000_0000_8000_0003, 64'h0000_0000_7FFF_4000,
             64'h0000_0000_8000_7FFF, 64'h0000_0000_8000_7FFF, 4'b0011, 4'b0010);
        idle(4);

        // stall for two cycles after beat 2; en during stall must not be taken
        step(1, 0, 0, 0, 64'h4000, 64'h4000, 64'h2000, 64'h2000, 4'b0000, 4'b0000);
        step(1, 0, 0, 0, 64'h2000, 64'h4000, 64'h1000, 64'h1000, 4'b0000, 4'b0000);
        step(1, 1, 0, 0, 64'h7FFF, 64'h7FFF, '0, '0, '0, '0);
        step(1, 1, 0, 0, 64'h7FFF, 64'h7FFF, '0, '0, '0, '0);
        step(1, 0, 0, 0, 64'h6000, 64'h4000, 64'h3000, 64'h3000, 4'b0000, 4'b0000);
        idle(4);

        // stall while a result is being presented
        step(1, 0, 0, 0, 64'h4000, 64'h4000, 64'h2000, 64'h2000, 4'b0000, 4'b0000);
        step(1, 0, 0, 0, 64'h2000, 64'h4000, 64'h1000, 64'h1000, 4'b0000, 4'b0000);
        idle(1);
        step(1, 1, 0, 0, 64'h7FFF, 64'h7FFF, '0, '0, '0, '0);
        step(1, 1, 0, 0, 64'h7FFF, 64'h7FFF, '0, '0, '0, '0);
        idle(4);

        // reset mid-accumulation, held together with stall
        step(1, 0, 1, 1, 64'h4000, 64'h4000, 64'h2000, 64'h2000, 4'b0000, 4'b0000);
        step(1, 0, 1, 0, 64'h4000, 64'h4000, 64'h4000, 64'h4000, 4'b0000, 4'b0000);
        do_reset(1);
        step(1, 0, 1, 0, 64'h4000, 64'h4000, 64'h2000, 64'h2000, 4'b0000, 4'b0000);
        idle(5);

        // reset asserted exactly while a result sits at the last stage
        step(1, 0, 0, 0, 64'h4000, 64'h4000, 64'h2000, 64'h2000, 4'b0000, 4'b0000);
        idle(2);
        do_reset(1);
        idle(5);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fxp_mac_array.md
FXP_MAC_ARRAY -- requirements
Module: fxp_mac_array

Interface
REQ-001 Parameter LANES, default 4: number of independent multiply/accumulate lanes.
REQ-002 Parameter A_WIDTH, default 16: per-lane signed a operand width.
REQ-003 Parameter B_WIDTH, default 16: per-lane signed b operand width.
REQ-004 Parameter A_FRAC, default 15: a fractional bits.
REQ-005 Parameter B_FRAC, default 15: b fractional bits.
REQ-006 Parameter OUT_WIDTH, default 16: per-lane signed result width.
REQ-007 Parameter OUT_FRAC, default 15: result fractional bits.
REQ-008 Parameter ACC_WIDTH, default 40: accumulator width; legal range is ACC_WIDTH >= A_WIDTH+B_WIDTH.
REQ-009 Parameter DELAY, default 3: input-to-output latency in enabled cycles; legal range is DELAY >= 3.
REQ-010 Parameter ROUND, default 1: 1 = round-half-up on right shift; 0 = truncate.
REQ-011 clk  input  1  clock; all state changes on rising edge.
REQ-012 reset  input  1  reset, synchronous, active-high.
REQ-013 en  input  1  beat valid; a_in, b_in, mode and acc_clear are sampled when en=1 and stall=0.
REQ-014 stall  input  1  global freeze; every register holds its value while stall=1.
REQ-015 mode  input  1  0 = multiply only; 1 = accumulate.
REQ-016 acc_clear  input  1  with mode=1, start a new accumulation from this beat.
REQ-017 a_in  input  LANES*A_WIDTH  packed signed operands; lane i occupies bits [i*A_WIDTH +: A_WIDTH].
REQ-018 b_in  input  LANES*B_WIDTH  packed signed operands, packed in the same way as a_in.
REQ-019 out  output  LANES*OUT_WIDTH  packed signed results.
REQ-020 sat  output  LANES  per-lane saturation flag, valid with done.
REQ-021 done  output  1  out and sat valid this cycle.

Function
REQ-022 Stage 1 SHALL register the full-precision signed product a*b, A_WIDTH+B_WIDTH bits, for each lane; it SHALL register mode and acc_clear alongside the product.
REQ-023 Stage 2, mode=0: each lane accumulator SHALL load the sign-extended product; accumulator contents are discarded.
REQ-024 Stage 2, mode=1, acc_clear=1: each lane accumulator SHALL load the sign-extended product.
REQ-025 Stage 2, mode=1, acc_clear=0: each lane accumulator SHALL load accumulator + product, saturated to the signed ACC_WIDTH range, and SHALL set an internal acc_sat flag when clamped.
REQ-026 The accumulator SHALL update only on valid beats; beats with en=0 leave it unchanged.
REQ-027 acc_clear with mode=0, or with en=0, SHALL have no effect.
REQ-028 Stage 3 SHALL scale by SH = A_FRAC+B_FRAC-OUT_FRAC, as follows.
  - SH>0: arithmetic right shift by SH; when ROUND=1, add 2^(SH-1) before the shift.
  - SH<0: left shift by -SH.
  - SH=0: no shift.
REQ-029 Stage 3 SHALL then clamp to [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1]; no intermediate SHALL wrap, and rounding overflow SHALL clamp.
REQ-030 sat[i] SHALL be 1 when lane i was clamped in stage 3, or its acc_sat flag was set for that beat.
REQ-031 Stages 4..DELAY SHALL be a delay line carrying out, sat and the valid bit.
REQ-032 Total latency SHALL be DELAY non-stalled cycles from the en sample edge to done=1.
REQ-033 Valid SHALL propagate as a bit per stage; done SHALL be that bit at the last stage ANDed with ~reset.
REQ-034 Back-to-back beats SHALL be accepted every non-stalled cycle, giving full throughput.
REQ-035 The stalled cycle count SHALL not count toward latency; out, sat and done SHALL hold steady during stall.
REQ-036 Simultaneous stall=1 and en=1: the beat SHALL NOT be sampled.
REQ-037 Lanes SHALL be fully independent; saturation in one lane SHALL NOT affect another lane.

Reset
REQ-038 While reset=1 at a rising edge, all pipeline registers, accumulators, valid bits and sat flags SHALL become 0.
REQ-039 While reset=1, done SHALL be 0 combinationally; after reset, out and sat SHALL read 0.
REQ-040 Reset SHALL override stall.
REQ-041 Reset mid-operation SHALL discard in-flight beats; no done SHALL appear for them.
REQ-042 After a mid-accumulation reset, the next mode=1 beat SHALL accumulate from 0.

Verification
Defaults for all scenarios: Q1.15 operands and result, SH=15.
REQ-043 Multiply: lane0 a=0x4000, b=0x4000, mode=0, one beat -> 3 cycles later done=1, out lane0=0x2000, sat=0.
REQ-044 Saturation: a=0x8000, b=0x8000, mode=0 -> out=0x7FFF, sat[0]=1; the other lanes (zero operands) give 0x0000, sat=0.
REQ-045 Accumulate: four consecutive beats a=b=0x4000, mode=1, acc_clear=1 on the first beat only.
  - Outputs SHALL be 0x2000, 0x4000, 0x6000, 0x7FFF.
  - sat SHALL be 1 on the fourth output only.
  - done SHALL be high for 4 consecutive cycles.
REQ-046 Rounding: a=0x0001, b=0x4000 -> ROUND=1 gives 0x0001; ROUND=0 gives 0x0000. With a=0xFFFF, b=0x4000 -> ROUND=1 gives 0x0000; ROUND=0 gives 0xFFFF.
REQ-047 Stall: stream 3 beats and assert stall for 2 cycles after beat 2.
  - out and done SHALL hold during the stall.
  - All 3 results SHALL emerge in order, with total latency DELAY+2 for the stalled beats.
REQ-048 Reset mid-accumulation: after 2 accumulate beats, pulse reset for 1 cycle, then issue one mode=1, acc_clear=0 beat a=b=0x4000 -> no done for the discarded beats; the next output SHALL be 0x2000.
